// File: rtl/serial_bus_sequencer.sv
// Shares one framed 8-bit memory bus (cmd, addr lo, addr hi, data) between instruction fetch and data load/store.
// Define SERIAL_BUS_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES blocked cycles on a single byte.
module serial_bus_sequencer #(
  parameter bit DATA_FIRST      = 1'b1,
  parameter int MAX_FETCH_BYTES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  input  logic        fetch_done,
  input  logic        fetch_err,
  output logic        fetch_byte_valid,
  output logic        fetch_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ack,
  output logic [7:0]  bus_out,
  output logic        bus_out_valid,
  input  logic        bus_ready,
  input  logic [7:0]  bus_in,
  input  logic        bus_in_valid,
  output logic        busy,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_LO, ADDR_HI, RD_DATA, WR_LO, WR_HI, FINISH, ERR
  } state_t;

  localparam int CW = $clog2(MAX_FETCH_BYTES + 1);

  if (MAX_FETCH_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("serial_bus_sequencer: MAX_FETCH_BYTES and TIMEOUT_CYCLES must be at least 1");
  end

  state_t        state;
  state_t        nxt;
  logic          is_fetch;
  logic          is_write;
  logic          rr_data;
  logic [15:0]   addr;
  logic [15:0]   wdata;
  logic [CW-1:0] byte_cnt;
  logic          grant_data;
  logic          timed_out;

  // Round-robin: rr_data set means the data port wins the next tie.
  always_comb begin
    if (fetch_req && mem_req) grant_data = DATA_FIRST ? 1'b1 : rr_data;
    else                      grant_data = mem_req;
  end

`ifdef SERIAL_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          blocked;

  always_comb begin
    case (state)
      CMD, ADDR_LO, ADDR_HI, WR_LO, WR_HI: blocked = !bus_ready;
      RD_DATA:                             blocked = !bus_in_valid;
      default:                             blocked = 1'b0;
    endcase
  end

  assign timed_out = blocked && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !blocked || nxt != state) wait_cnt <= '0;
    else                                 wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (fetch_req || mem_req) nxt = CMD;
      CMD:     if (bus_ready) nxt = ADDR_LO; else if (timed_out) nxt = ERR;
      ADDR_LO: if (bus_ready) nxt = ADDR_HI; else if (timed_out) nxt = ERR;
      ADDR_HI: if (bus_ready) nxt = is_write ? WR_LO : RD_DATA;
               else if (timed_out) nxt = ERR;
      WR_LO:   if (bus_ready) nxt = WR_HI; else if (timed_out) nxt = ERR;
      WR_HI:   if (bus_ready) nxt = FINISH; else if (timed_out) nxt = ERR;
      RD_DATA: begin
        // fetch_done outranks the byte limit so an instruction ending on the last byte still completes.
        if (is_fetch) begin
          if (fetch_done)                          nxt = FINISH;
          else if (fetch_err)                      nxt = ERR;
          else if (byte_cnt >= CW'(MAX_FETCH_BYTES)) nxt = ERR;
          else if (timed_out)                      nxt = ERR;
        end else begin
          if (bus_in_valid && byte_cnt[0])         nxt = FINISH;
          else if (timed_out)                      nxt = ERR;
        end
      end
      FINISH:  nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_fetch  <= 1'b0;
      is_write  <= 1'b0;
      rr_data   <= 1'b1;
      addr      <= '0;
      wdata     <= '0;
      byte_cnt  <= '0;
      mem_rdata <= '0;
      mem_ack   <= 1'b0;
      fetch_ack <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= nxt;
      mem_ack   <= 1'b0;
      fetch_ack <= 1'b0;
      case (state)
        IDLE: if (fetch_req || mem_req) begin
          is_fetch <= !grant_data;
          is_write <= grant_data && mem_we;
          addr     <= grant_data ? mem_addr : fetch_addr;
          wdata    <= mem_wdata;
        end
        RD_DATA: if (bus_in_valid) begin
          byte_cnt <= byte_cnt + 1'b1;
          if (!is_fetch) begin
            if (byte_cnt[0]) mem_rdata[15:8] <= bus_in;
            else             mem_rdata[7:0]  <= bus_in;
          end
        end
        FINISH, ERR: begin
          byte_cnt <= '0;
          rr_data  <= is_fetch;
        end
        default: ;
      endcase
      // Acks are raised on entry so they are high during the FINISH/ERR cycle itself.
      if (nxt == FINISH || nxt == ERR) begin
        mem_ack   <= !is_fetch;
        fetch_ack <= is_fetch;
      end
      if (nxt == ERR) begin
        error     <= 1'b1;
        mem_rdata <= '0;
      end
    end
  end

  always_comb begin
    bus_out       = 8'h00;
    bus_out_valid = 1'b1;
    case (state)
      CMD:     bus_out = is_write ? 8'h02 : 8'h01;
      ADDR_LO: bus_out = addr[7:0];
      ADDR_HI: bus_out = addr[15:8];
      WR_LO:   bus_out = wdata[7:0];
      WR_HI:   bus_out = wdata[15:8];
      default: bus_out_valid = 1'b0;
    endcase
  end

  assign busy             = (state != IDLE);
  assign fetch_byte_valid = (state == RD_DATA) && is_fetch && bus_in_valid;

endmodule

// File: tb/tb_serial_bus_sequencer.sv
// Scoreboarded bench for serial_bus_sequencer: bus bytes, fetch bytes and completions are queued at stimulus time.
`timescale 1ns/1ps
module tb_serial_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0, fetch_done = 1'b0, fetch_err = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [15:0] mem_addr = '0, mem_wdata = '0;
  logic        bus_ready = 1'b1, bus_in_valid = 1'b0;
  logic [7:0]  bus_in = '0;
  logic        fetch_byte_valid, fetch_ack, mem_ack, bus_out_valid, busy, error;
  logic [15:0] mem_rdata;
  logic [7:0]  bus_out;

  logic        rr_fbv, rr_fack, rr_mack, rr_bov, rr_busy, rr_err;
  logic [15:0] rr_rdata;
  logic [7:0]  rr_bus_out;

  always #5 clk = ~clk;

  serial_bus_sequencer #(.DATA_FIRST(1'b1), .MAX_FETCH_BYTES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done), .fetch_err(fetch_err),
    .fetch_byte_valid(fetch_byte_valid), .fetch_ack(fetch_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_out(bus_out), .bus_out_valid(bus_out_valid), .bus_ready(bus_ready),
    .bus_in(bus_in), .bus_in_valid(bus_in_valid), .busy(busy), .error(error)
  );

  // Round-robin instance: both requesters and the memory side permanently ready.
  serial_bus_sequencer #(.DATA_FIRST(1'b0), .MAX_FETCH_BYTES(4), .TIMEOUT_CYCLES(8)) dut_rr (
    .clk(clk), .rst(rst),
    .fetch_req(1'b1), .fetch_addr(16'h0200), .fetch_done(1'b1), .fetch_err(1'b0),
    .fetch_byte_valid(rr_fbv), .fetch_ack(rr_fack),
    .mem_req(1'b1), .mem_we(1'b0), .mem_addr(16'h0100), .mem_wdata(16'h0000),
    .mem_rdata(rr_rdata), .mem_ack(rr_mack),
    .bus_out(rr_bus_out), .bus_out_valid(rr_bov), .bus_ready(1'b1),
    .bus_in(8'h5A), .bus_in_valid(1'b1), .busy(rr_busy), .error(rr_err)
  );

  typedef struct {
    logic        fetch;
    logic        chk_rd;
    logic [15:0] rdata;
    logic        err;
  } cpl_t;

  logic [7:0] exp_bus[$];
  logic [7:0] exp_fb[$];
  cpl_t       exp_cpl[$];
  logic       rr_seq[$];
  cpl_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         fb_cnt = 0;
  int         ack_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_out_valid && bus_ready) begin
        if (exp_bus.size() == 0) check("bus_extra", 32'(bus_out_valid), 32'd0);
        else                     check("bus_byte", 32'(bus_out), 32'(exp_bus.pop_front()));
      end
      if (fetch_byte_valid) begin
        fb_cnt++;
        if (exp_fb.size() == 0) check("fbyte_extra", 32'(fetch_byte_valid), 32'd0);
        else                    check("fbyte", 32'(bus_in), 32'(exp_fb.pop_front()));
      end
      if (mem_ack || fetch_ack) begin
        ack_cnt++;
        check("ack_onehot", 32'(mem_ack & fetch_ack), 32'd0);
        if (exp_cpl.size() == 0) check("ack_extra", 32'(mem_ack | fetch_ack), 32'd0);
        else begin
          mon_e = exp_cpl.pop_front();
          check("ack_kind", 32'(fetch_ack), 32'(mon_e.fetch));
          if (mon_e.chk_rd) check("rdata", 32'(mem_rdata), 32'(mon_e.rdata));
          check("err_flag", 32'(error), 32'(mon_e.err));
        end
      end
      if ((rr_mack || rr_fack) && rr_seq.size() < 4) rr_seq.push_back(rr_fack);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 200) begin
      @(negedge clk);
      if (bus_out_valid && bus_ready) seen++;
      cyc++;
    end
    check("hs_timeout", 32'(seen), 32'(n));
    tick();
  endtask

  task automatic wait_ack(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(mem_ack || fetch_ack) && cycles < 200);
    check("ack_timeout", 32'(mem_ack | fetch_ack), 32'd1);
    tick();
  endtask

  task automatic feed(input logic [7:0] b);
    bus_in = b;
    bus_in_valid = 1'b1;
    tick();
    bus_in_valid = 1'b0;
    bus_in = 8'h00;
  endtask

  task automatic push_hdr(input logic [7:0] cmd, input logic [15:0] a);
    exp_bus.push_back(cmd);
    exp_bus.push_back(a[7:0]);
    exp_bus.push_back(a[15:8]);
  endtask

  task automatic push_cpl(input logic f, input logic c, input logic [15:0] d, input logic e);
    cpl_t x;
    x.fetch = f; x.chk_rd = c; x.rdata = d; x.err = e;
    exp_cpl.push_back(x);
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] d, input logic err_exp);
    int c;
    mem_addr = a; mem_we = 1'b0; mem_req = 1'b1;
    push_hdr(8'h01, a);
    push_cpl(1'b0, 1'b1, d, err_exp);
    wait_hs(3);
    feed(d[7:0]);
    feed(d[15:8]);
    wait_ack(c);
    check("ld_finish_lat", 32'(c), 32'd1);
    mem_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [15:0] a, input int n, input logic done, input logic err_exp);
    int c;
    int fb0 = fb_cnt;
    fetch_addr = a; fetch_req = 1'b1;
    push_hdr(8'h01, a);
    push_cpl(1'b1, !done, 16'h0000, err_exp);
    for (int i = 0; i < n; i++) exp_fb.push_back(8'(8'hA0 + i));
    wait_hs(3);
    for (int i = 0; i < n; i++) feed(8'(8'hA0 + i));
    if (done) begin
      fetch_done = 1'b1;
      tick();
      fetch_done = 1'b0;
    end
    wait_ack(c);
    fetch_req = 1'b0;
    check("fb_pulses", 32'(fb_cnt - fb0), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int acks0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bov", 32'(bus_out_valid), 32'd0);
    check("rst_rdata", 32'(mem_rdata), 32'd0);
    check("rst_acks", 32'({mem_ack, fetch_ack, fetch_byte_valid}), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    do_load(16'h1234, 16'hABCD, 1'b0);

    // Store with three stalled cycles on the address-low byte.
    mem_addr = 16'h0040; mem_wdata = 16'hBEEF; mem_we = 1'b1; mem_req = 1'b1;
    push_hdr(8'h02, 16'h0040);
    exp_bus.push_back(8'hEF);
    exp_bus.push_back(8'hBE);
    push_cpl(1'b0, 1'b0, 16'h0000, 1'b0);
    wait_hs(1);
    bus_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("hold_byte", 32'(bus_out), 32'h40);
      check("hold_vld", 32'(bus_out_valid), 32'd1);
    end
    tick();
    bus_ready = 1'b1;
    wait_ack(c);
    mem_req = 1'b0;

    // Unstalled store: ack six cycles after the grant cycle.
    mem_addr = 16'h1357; mem_wdata = 16'hA55A; mem_we = 1'b1; mem_req = 1'b1;
    push_hdr(8'h02, 16'h1357);
    exp_bus.push_back(8'h5A);
    exp_bus.push_back(8'hA5);
    push_cpl(1'b0, 1'b0, 16'h0000, 1'b0);
    wait_ack(c);
    check("st_latency", 32'(c), 32'd7);
    mem_req = 1'b0;

    do_fetch(16'h0010, 2, 1'b1, 1'b0);

    // Both pending with data priority: data, then fetch, then a data request raised mid-fetch.
    mem_addr = 16'h0100; mem_we = 1'b0; fetch_addr = 16'h0200;
    push_hdr(8'h01, 16'h0100);
    push_cpl(1'b0, 1'b1, 16'h1111, 1'b0);
    mem_req = 1'b1; fetch_req = 1'b1;
    wait_hs(3);
    feed(8'h11); feed(8'h11);
    wait_ack(c);
    mem_req = 1'b0;
    push_hdr(8'h01, 16'h0200);
    push_cpl(1'b1, 1'b0, 16'h0000, 1'b0);
    exp_fb.push_back(8'hA0);
    wait_hs(1);
    mem_addr = 16'h0300; mem_req = 1'b1;
    push_hdr(8'h01, 16'h0300);
    push_cpl(1'b0, 1'b1, 16'h2233, 1'b0);
    wait_hs(2);
    feed(8'hA0);
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    wait_ack(c);
    fetch_req = 1'b0;
    wait_hs(3);
    feed(8'h33); feed(8'h22);
    wait_ack(c);
    mem_req = 1'b0;

    // Reset while the first write-data byte is on the bus.
    mem_addr = 16'h2222; mem_wdata = 16'h7777; mem_we = 1'b1; mem_req = 1'b1;
    push_hdr(8'h02, 16'h2222);
    wait_hs(3);
    acks0 = ack_cnt;
    rst = 1'b1; mem_req = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bov", 32'(bus_out_valid), 32'd0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("midrst_no_ack", 32'(ack_cnt - acks0), 32'd0);
    do_load(16'h0456, 16'h9876, 1'b0);

`ifdef SERIAL_BUS_TIMEOUT_EN
    mem_addr = 16'h0ABC; mem_we = 1'b0; mem_req = 1'b1;
    push_hdr(8'h01, 16'h0ABC);
    push_cpl(1'b0, 1'b1, 16'h0000, 1'b1);
    wait_hs(3);
    wait_ack(c);
    check("timeout_cycles", 32'(c), 32'd9);
    mem_req = 1'b0;
    check("timeout_sticky", 32'(error), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("err_cleared", 32'(error), 32'd0);
`endif

    // Four fetch bytes without fetch_done: error completion, then error stays set.
    do_fetch(16'h0020, 4, 1'b0, 1'b1);
    do_load(16'h0ACE, 16'h5AA5, 1'b1);
    check("err_sticky", 32'(error), 32'd1);

    check("rr_count", 32'(rr_seq.size()), 32'd4);
    for (int i = 0; i < 4 && i < rr_seq.size(); i++) check("rr_order", 32'(rr_seq[i]), 32'(i % 2));
    check("bus_q_left", 32'(exp_bus.size()), 32'd0);
    check("fb_q_left", 32'(exp_fb.size()), 32'd0);
    check("cpl_q_left", 32'(exp_cpl.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bus_sequencer.md
Name: serial_bus_sequencer

Overview:
- Owns the single 8-bit byte bus to external memory and shares it between two requesters: instruction fetch (PC side) and data load/store (register side).
- Issues a framed transaction on the bus: command byte, address low, address high, then data bytes.
- Fetch bytes stream to the instruction shift register. Data reads are assembled into a 16-bit word.
- Sits between the PC/instruction registers, the execute stage and the off-chip memory interface.

Parameters:
- DATA_FIRST, 1, priority when both requesters are pending: 1 = data port wins, 0 = alternate (round-robin, last-granted loses).
- MAX_FETCH_BYTES, 4, fetch aborts with error if fetch_done has not arrived after this many bytes.
- TIMEOUT_CYCLES, 64, wait-cycle limit per byte (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request, level, held until fetch_ack
- fetch_addr  in  16  PC value to fetch from
- fetch_done  in  1  instruction register reports a complete instruction
- fetch_err  in  1  instruction register reports a bad opcode
- fetch_byte_valid  out  1  one-cycle strobe, bus_in byte is for the instruction register
- fetch_ack  out  1  one-cycle pulse, fetch finished
- mem_req  in  1  data request, level, held until mem_ack
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  16  data address
- mem_wdata  in  16  store data
- mem_rdata  out  16  load result, valid with mem_ack
- mem_ack  out  1  one-cycle pulse, data transaction finished
- bus_out  out  8  byte to memory
- bus_out_valid  out  1  bus_out is presented
- bus_ready  in  1  memory accepts bus_out this cycle
- bus_in  in  8  byte from memory
- bus_in_valid  in  1  bus_in carries a valid byte
- busy  out  1  state is not IDLE
- error  out  1  sticky error flag, cleared only by rst

Behaviour:
- States: IDLE, CMD, ADDR_LO, ADDR_HI, RD_DATA, WR_LO, WR_HI, FINISH, ERR.
- Reset: state IDLE. All outputs 0, including mem_rdata. Byte counter 0. Round-robin pointer favours data.
- IDLE grant:
  - Evaluated each cycle; the requester's address, we and wdata are latched on grant.
  - The grant moves to CMD on the next cycle.
  - Both pending: arbitrate per DATA_FIRST.
- CMD:
  - bus_out = 0x01 for read, 0x02 for write. Fetch is always a read.
  - bus_out_valid = 1. Advance only on a cycle where bus_ready = 1; otherwise hold the byte unchanged.
- ADDR_LO / ADDR_HI: send latched address bits [7:0] then [15:8], same ready rule as CMD.
- After ADDR_HI: write goes to WR_LO; read goes to RD_DATA.
- WR_LO / WR_HI: send wdata [7:0] then [15:8] with the ready rule, then go to FINISH.
- RD_DATA, data read:
  - Capture the first bus_in_valid byte into mem_rdata[7:0] and the second into [15:8].
  - Go to FINISH after the second byte.
- RD_DATA, fetch:
  - Each bus_in_valid cycle pulses fetch_byte_valid in the same cycle (combinational passthrough) and increments the byte counter.
  - fetch_done = 1 goes to FINISH. fetch_done takes priority over the counter check in the same cycle.
  - fetch_err = 1 goes to ERR.
  - Counter reaches MAX_FETCH_BYTES without fetch_done: go to ERR.
- FINISH:
  - One cycle. Pulse fetch_ack or mem_ack for the granted requester.
  - Clear the counter, update the round-robin pointer, return to IDLE.
  - A new grant is possible on the following cycle.
- ERR:
  - Set error. Pulse the granted requester's ack with mem_rdata = 0.
  - Return to IDLE; error stays set.
- Bytes on bus_in while not in RD_DATA are ignored.
- Requests dropped mid-transaction are ignored; the transaction completes.
- rst mid-transaction: immediate return to IDLE, bus_out_valid = 0 in the next cycle, no ack.
- Minimum latency: read 2 + 3 bytes + 2 data bytes + FINISH; write 6 cycles after grant when ready and valid are always high.

Optional Feature:
- Macro: SERIAL_BUS_TIMEOUT_EN.
- Defined:
  - A wait counter resets on every state advance and increments while blocked on bus_ready or bus_in_valid.
  - Reaching TIMEOUT_CYCLES goes to ERR.
- Undefined: no counter; the sequencer waits indefinitely.

Test Plan:
- Load 0x1234, bus_ready=1, bus_in 0xCD then 0xAB:
  - bus_out shows 0x01, 0x34, 0x12.
  - mem_rdata = 0xABCD with a single mem_ack.
- Store 0xBEEF to 0x0040:
  - bus_out shows 0x02, 0x40, 0x00, 0xEF, 0xBE.
  - bus_ready low for 3 cycles on the 0x40 byte holds 0x40 stable.
- Fetch from 0x0010:
  - Two fetch_byte_valid pulses, then fetch_done asserted: fetch_ack pulse, error 0.
  - Repeat with four bytes and no fetch_done: error = 1, ack pulse.
- fetch_req and mem_req asserted together, both held:
  - DATA_FIRST=1: data, fetch, data order.
  - DATA_FIRST=0: grants alternate.
- rst asserted during WR_LO:
  - busy = 0 and bus_out_valid = 0 the next cycle, no mem_ack.
  - A new load then completes normally.
- SERIAL_BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, bus_in_valid held low in RD_DATA: ERR after 8 cycles, error = 1, mem_ack with mem_rdata = 0.
